// File: rtl/tdm_pkg.sv
// tdm_pkg: shared slot numbering, widths and alignment states for the 4-slot TDM receiver
package tdm_pkg;
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W = 2;
  typedef enum logic {HUNT, LOCKED} state_t;
  // slot k matches the transmit mux select {s1,s0} = k
  localparam logic [SLOT_W-1:0] SLOT0 = 2'd0;
  localparam logic [SLOT_W-1:0] SLOT1 = 2'd1;
  localparam logic [SLOT_W-1:0] SLOT2 = 2'd2;
  localparam logic [SLOT_W-1:0] SLOT3 = 2'd3;
endpackage

// File: rtl/tdm_sync_fsm.sv
// tdm_sync_fsm: frame alignment (HUNT/LOCKED), slot counter and sync error detection
// Ports: clk, rst_n (async low); en/fsync slot strobe and sync;
//   wr/wr_slot capture strobe and stage index, load (slot 3 completes frame), err (alignment error);
//   locked, sync_err, frame_valid registered status outputs.
module tdm_sync_fsm
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              fsync,
  output logic              wr,
  output logic [SLOT_W-1:0] wr_slot,
  output logic              load,
  output logic              err,
  output logic              locked,
  output logic              sync_err,
  output logic              frame_valid
);
  state_t            state;
  logic [SLOT_W-1:0] cnt;
  // fsync always restarts a frame at slot 0; without fsync only a locked mid-frame slot is kept
  assign wr      = en & (fsync | (state == LOCKED && cnt != SLOT0));
  assign wr_slot = fsync ? SLOT0 : cnt;
  assign load    = en & ~fsync & (state == LOCKED) & (cnt == SLOT3);
  // misplaced sync (fsync mid-frame) or missing sync (no fsync at slot 0)
  assign err     = en & (state == LOCKED) & (fsync ? cnt != SLOT0 : cnt == SLOT0);
  assign locked  = state == LOCKED;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= HUNT;
      cnt         <= SLOT0;
      sync_err    <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      sync_err    <= err;
      frame_valid <= load;
      if (en) begin
        // a discarded slot drops to HUNT (missing sync) or stays in HUNT
        state <= wr ? LOCKED : HUNT;
        cnt   <= wr ? wr_slot + 1'b1 : SLOT0;
      end
    end
endmodule

// File: rtl/tdm_demux4_rx.sv
// tdm_demux4_rx: 4-slot TDM receiver, aligns on fsync and presents complete frames on y0..y3
// Ports: clk, rst_n (async low); en slot strobe, din slot data, fsync slot-0 sync;
//   y0..y3 last complete frame, frame_valid pulse on update, locked, sync_err pulse,
//   err_cnt saturating error count.
module tdm_demux4_rx
  import tdm_pkg::*;
#(
  parameter int W = 1,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [W-1:0]     din,
  input  logic             fsync,
  output logic [W-1:0]     y0,
  output logic [W-1:0]     y1,
  output logic [W-1:0]     y2,
  output logic [W-1:0]     y3,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err,
  output logic [ERR_W-1:0] err_cnt
);
  logic              wr, load, err;
  logic [SLOT_W-1:0] wr_slot;
  logic [W-1:0]      s0, s1, s2;
  tdm_sync_fsm u_fsm (
    .clk(clk), .rst_n(rst_n), .en(en), .fsync(fsync),
    .wr(wr), .wr_slot(wr_slot), .load(load), .err(err),
    .locked(locked), .sync_err(sync_err), .frame_valid(frame_valid)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s0      <= '0;
      s1      <= '0;
      s2      <= '0;
      y0      <= '0;
      y1      <= '0;
      y2      <= '0;
      y3      <= '0;
      err_cnt <= '0;
    end else begin
      s0 <= (wr && wr_slot == SLOT0) ? din : s0;
      s1 <= (wr && wr_slot == SLOT1) ? din : s1;
      s2 <= (wr && wr_slot == SLOT2) ? din : s2;
      // slot 3 is never staged: it goes straight to y3 with the staged slots
      if (load) begin
        y0 <= s0;
        y1 <= s1;
        y2 <= s2;
        y3 <= din;
      end
      err_cnt <= (err && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
    end
endmodule

// File: tb/tb_tdm_demux4_rx.sv
// tb_tdm_demux4_rx: randomized and directed checks of tdm_demux4_rx against a frame-queue model
module tb_tdm_demux4_rx;
  logic       clk = 0, rst_n = 0, en = 0, fsync = 0;
  logic [7:0] din = 0;
  logic [7:0] a_y0, a_y1, a_y2, a_y3, a_cnt;
  logic       a_fv, a_lk, a_se;
  logic       b_y0, b_y1, b_y2, b_y3, b_fv, b_lk, b_se;
  logic [1:0] b_cnt;
  int checks = 0, errors = 0;
  bit         m_lk, m_fv, m_err;
  logic [7:0] m_q[$];
  logic [7:0] m_y[4];
  int         m_errs;

  always #5 clk = ~clk;

  tdm_demux4_rx #(.W(8), .ERR_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .fsync(fsync),
    .y0(a_y0), .y1(a_y1), .y2(a_y2), .y3(a_y3), .frame_valid(a_fv),
    .locked(a_lk), .sync_err(a_se), .err_cnt(a_cnt)
  );
  tdm_demux4_rx #(.W(1), .ERR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din[0]), .fsync(fsync),
    .y0(b_y0), .y1(b_y1), .y2(b_y2), .y3(b_y3), .frame_valid(b_fv),
    .locked(b_lk), .sync_err(b_se), .err_cnt(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lk = 0; m_fv = 0; m_err = 0; m_errs = 0;
    m_q = {};
    for (int i = 0; i < 4; i++) m_y[i] = 0;
  endtask

  // a frame is the queue of slots gathered since the last sync; four slots make a frame
  task automatic model_step(input bit e, input bit f, input logic [7:0] d);
    m_fv = 0; m_err = 0;
    if (!e) return;
    if (!m_lk) begin
      if (f) begin m_q = {d}; m_lk = 1; end
    end else if (f) begin
      if (m_q.size() != 0) m_err = 1;
      m_q = {d};
    end else if (m_q.size() == 0) begin
      m_err = 1; m_lk = 0;
    end else begin
      m_q.push_back(d);
      if (m_q.size() == 4) begin
        for (int i = 0; i < 4; i++) m_y[i] = m_q[i];
        m_fv = 1;
        m_q = {};
      end
    end
    if (m_err) m_errs++;
  endtask

  task automatic check_all();
    chk("a_y", {a_y0, a_y1, a_y2, a_y3}, {m_y[0], m_y[1], m_y[2], m_y[3]});
    chk("b_y", {b_y0, b_y1, b_y2, b_y3}, {m_y[0][0], m_y[1][0], m_y[2][0], m_y[3][0]});
    chk("frame_valid", {a_fv, b_fv}, {m_fv, m_fv});
    chk("locked", {a_lk, b_lk}, {m_lk, m_lk});
    chk("sync_err", {a_se, b_se}, {m_err, m_err});
    chk("a_err_cnt", a_cnt, m_errs > 255 ? 255 : m_errs);
    chk("b_err_cnt", b_cnt, m_errs > 3 ? 3 : m_errs);
  endtask

  task automatic step(input bit e, input bit f, input logic [7:0] d);
    en = e; fsync = f; din = d;
    @(posedge clk);
    model_step(e, f, d);
    #1 check_all();
  endtask

  task automatic frame(input logic [7:0] d0, d1, d2, d3);
    step(1, 1, d0); step(1, 0, d1); step(1, 0, d2); step(1, 0, d3);
  endtask

  task automatic do_reset();
    rst_n = 0; en = 0; fsync = 0;
    #2;
    model_reset();
    check_all();
    chk("reset_cnt", {a_cnt, 6'd0, b_cnt}, 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    #1 check_all();
  endtask

  initial begin
    model_reset();
    do_reset();
    // three contiguous W=1 style frames
    frame(1, 0, 1, 1);
    chk("lock_after_sync", a_lk, 1);
    frame(0, 1, 0, 0);
    frame(1, 1, 1, 1);
    step(1, 1, 8'h55);
    // en toggling frame
    do_reset();
    step(1, 1, 8'hA1); step(0, 0, 8'hFF);
    step(1, 0, 8'hB2); step(0, 1, 8'hEE);
    step(1, 0, 8'hC3); step(0, 1, 8'hDD);
    step(1, 0, 8'hD4); step(0, 0, 8'h00);
    chk("toggle_frame", {a_y0, a_y1, a_y2, a_y3}, 32'hA1B2C3D4);
    // misplaced sync at cnt=2
    frame(8'h11, 8'h12, 8'h13, 8'h14);
    step(1, 1, 8'h21); step(1, 0, 8'h22);
    step(1, 1, 8'h31);
    chk("misplaced_hold", {a_y0, a_y1, a_y2, a_y3}, 32'h11121314);
    step(1, 0, 8'h32); step(1, 0, 8'h33); step(1, 0, 8'h34);
    chk("misplaced_frame", {a_y0, a_y1, a_y2, a_y3}, 32'h31323334);
    // missing sync then relock
    step(1, 0, 8'h41);
    chk("missing_unlock", a_lk, 0);
    step(1, 0, 8'h42);
    frame(8'h51, 8'h52, 8'h53, 8'h54);
    // repeated misplaced syncs to saturate the narrow counter
    step(1, 1, 8'h61);
    repeat (5) step(1, 1, 8'h62);
    chk("b_sat", b_cnt, 3);
    // reset mid-frame
    step(1, 1, 8'h71); step(1, 0, 8'h72);
    do_reset();
    frame(8'h81, 8'h82, 8'h83, 8'h84);
    chk("post_reset_frame", {a_y0, a_y1, a_y2, a_y3}, 32'h81828384);
    // randomized traffic with occasional sync corruption and gaps
    for (int i = 0; i < 3000; i++) begin
      bit at0, e, f;
      at0 = !m_lk || m_q.size() == 0;
      e = $urandom_range(0, 3) != 0;
      f = at0 ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 15) == 0);
      step(e, f, 8'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tdm_demux4_rx.md
Name: tdm_demux4_rx

Overview:
- Receive end of a 4-slot time-division link whose transmit side is a 4:1 mux with a 2-bit slot counter on its selects (s1,s0).
- Samples one W-bit slot per enabled cycle, in slot order 0,1,2,3, and distributes each slot to lane y0..y3.
- Tracks frame alignment from a slot-0 sync strobe and presents complete frames on the four lane outputs.

Parameters:
- W, 1, bits per slot and per lane output.
- ERR_W, 8, width of the saturating sync-error counter.

Ports:
- clk  in  1  single clock; all flops rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  slot strobe; din/fsync are sampled only when en=1.
- din  in  W  slot data from the link.
- fsync  in  1  high with en during slot 0 of every frame.
- y0  out  W  lane 0 data (slot 0) of the last complete frame.
- y1  out  W  lane 1 data (slot 1) of the last complete frame.
- y2  out  W  lane 2 data (slot 2) of the last complete frame.
- y3  out  W  lane 3 data (slot 3) of the last complete frame.
- frame_valid  out  1  one-cycle pulse when y0..y3 update.
- locked  out  1  frame alignment held.
- sync_err  out  1  one-cycle pulse on an alignment error.
- err_cnt  out  ERR_W  saturating count of sync_err pulses.

Behaviour:
- Reset (async assert, sync release):
  - State goes to HUNT; slot counter and staging regs clear.
  - y0..y3=0, frame_valid=0, locked=0, sync_err=0, err_cnt=0.
  - Reset mid-frame discards the partial frame.
- en=0: all state holds; fsync and din are ignored; pulses are low.
- HUNT:
  - en & fsync: capture din into stage0, cnt<=1, go LOCKED.
  - en & !fsync: the slot is discarded.
  - locked=0 in HUNT.
- LOCKED (locked=1):
  - Each en captures din into stage[cnt] and increments cnt (wraps 3->0).
  - On the en with cnt=3: stage0..2 plus the current din load y0..y3 at the same edge. frame_valid=1 for the following cycle only (registered pulse aligned with the new y values).
  - en & fsync & cnt!=0 (misplaced sync):
    - sync_err pulse; err_cnt+1.
    - Partial frame is discarded and y is unchanged.
    - din is captured as slot 0; cnt<=1; stays LOCKED.
  - en & !fsync & cnt=0 (missing sync):
    - sync_err pulse; err_cnt+1.
    - Go HUNT; the slot is discarded; y is unchanged.
- Latency: y updates at the clock edge that samples slot 3. frame_valid is high in the cycle after that edge.
- err_cnt saturates at 2^ERR_W-1; sync_err still pulses at saturation.
- y0..y3 hold the last good frame indefinitely, including through loss of lock.
- Frames may be non-contiguous: any number of en=0 cycles between slots is legal.

Decomposition:
- Shared package tdm_pkg:
  - NUM_SLOTS=4, SLOT_W=2.
  - state enum {HUNT, LOCKED}.
  - Same slot numbering constants as the transmit-side mux select encoding (slot k = {s1,s0}=k).
- One natural sub-module: tdm_sync_fsm (HUNT/LOCKED, slot counter, sync_err generation).
- Datapath (staging, lane regs, err_cnt) lives in the top.

Test Plan:
- Reset then 3 contiguous frames, W=1, slots 1,0,1,1 / 0,1,0,0 / 1,1,1,1, en=1 always:
  - locked=1 after first fsync.
  - frame_valid pulses 3 times, 4 cycles apart.
  - {y0,y1,y2,y3} = 1011, then 0100, then 1111.
- W=8, slots 0xA1,0xB2,0xC3,0xD4 with en toggling 1,0,1,0,...:
  - y0=0xA1, y1=0xB2, y2=0xC3, y3=0xD4.
  - Exactly one frame_valid; no sync_err.
- Locked; fsync asserted at cnt=2:
  - sync_err pulse, err_cnt=1, locked stays 1.
  - Next 3 slots complete a frame starting at the misplaced sync.
  - y unchanged until that frame completes.
- Locked; fsync absent at slot 0:
  - sync_err, err_cnt+1, locked=0, y holds the previous frame.
  - Next fsync relocks and a frame completes 4 enabled slots later.
- ERR_W=2, force 5 sync errors: err_cnt = 1,2,3,3,3; sync_err pulses 5 times.
- rst_n low after slot 1 of a frame, then release and a clean frame:
  - All outputs 0 during reset, locked=0.
  - Partial data never appears on y; the first frame_valid carries only post-reset data.
